mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - CPU-side initiator for the word-only data RAM (sync read, 1-cycle latency; sync write; no byte enables).
// - Accepts lw/lh/lhu/lb/lbu/sw/sh/sb requests and drives the RAM port; sub-word stores by read-modify-write.
// - Sits between the CPU datapath (stalls on busy) and the data RAM; little-endian lanes, MARS data segment.
// PARAMETERS
// - BASE_ADDR  32'h1001_0000  byte address of RAM word 0
// - DEPTH      1024           RAM depth in 32-bit words
// PORTS
// - clk        in   1   rising-edge clock, single clock domain
// - rst_n      in   1   asynchronous reset, active low
// - req        in   1   request strobe; sampled only in IDLE
// - we         in   1   1 = store, 0 = load
// - size       in   2   00 byte, 01 halfword, 10 word, 11 illegal
// - sign_ext   in   1   loads: 1 = sign-extend, 0 = zero-extend (ignored for word/stores)
// - addr       in   32  byte address
// - wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - rdata      out  32  load result, right-aligned/extended; holds until next load completes
// - busy       out  1   state != IDLE
// - done       out  1   one-cycle pulse on completion (also for faulted requests)
// - fault      out  1   valid with done: misaligned/illegal/out-of-range; no RAM access made
// - ram_rena   out  1   RAM read enable
// - ram_wena   out  1   RAM write enable
// - ram_addr   out  32  word-aligned byte address {addr[31:2],2'b00}
// - ram_din    out  32  RAM write data
// - ram_dout   in   32  RAM read data, valid the cycle after ram_rena
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, rdata=0, done=0, fault=0, latched req regs=0; ram_rena/ram_wena=0.
// - RAM strobes decode from state only (no combinational path from req); ram_addr/ram_din from latched regs.
// - FSM states IDLE, RD, CAP, WR, FIN. Request latched (we,size,sign_ext,addr,wdata) on accepting edge.
//   IDLE: req=1 & fault -> FIN; load or sub-word store -> RD; word store -> WR.
//   RD:  ram_rena=1 -> CAP.   CAP: ram_dout valid; load: register rdata -> FIN;
//        sub-word store: register merged word -> WR.   WR: ram_wena=1, ram_din=merged/wdata -> FIN.
//   FIN: done=1 (fault=1 if faulted) -> IDLE. done/fault are 0 in all other states.
// - Latency (accept edge to done cycle): fault 1, word store 2, load 3, sub-word store 4 cycles.
// - Back-to-back: req in FIN cycle ignored; next accepted in the following IDLE cycle. req while busy ignored.
// - Lane select: byte lane addr[1:0]; half lane addr[1] (bits [15:0] or [31:16]).
// - Merge: sb replaces byte lane with wdata[7:0]; sh replaces half lane with wdata[15:0]; other bits from RAM.
// - Load extend: lb/lh copy bit 7/15 when sign_ext=1, else zero-fill; lw passes word through.
// - Fault: size=11; half with addr[0]=1; word with addr[1:0]!=0; out-of-range (see CONFIGURATION).
//   Faulted request: no ram_rena/ram_wena ever asserted, rdata unchanged.
// - Reset mid-operation: FSM returns to IDLE; a store interrupted before WR leaves RAM unmodified; no done.
// CONFIGURATION
// - MEM_RANGE_CHECK_EN defined: addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH faults (32-bit unsigned
//   compare, no wrap; end bound computed in 33 bits).
// - Not defined: no range check; out-of-range addresses proceed to RAM (index wraps in RAM), fault only
//   from size/alignment.
// TESTING
// - Reset: rst_n=0 mid-RD -> next sample rdata=0, busy=0, done=0, ram_rena=0 before any clock edge.
// - sw 0x1001_0000 <- 0xDEADBEEF then lw same -> store done 2 cycles after accept, load rdata=0xDEADBEEF 3 cycles after.
// - sb 0x1001_0002 <- 0x55 over 0xDEADBEEF -> exactly one RD, one WR, RAM word 0xDE55BEEF, done 4 cycles after.
// - lb 0x1001_0000 sign_ext=1 on 0xDE55BEEF -> 0xFFFFFFEF; lhu 0x1001_0002 -> 0x0000DE55; lh 0x1001_0002 -> 0xFFFFDE55.
// - lw 0x1001_0001, sh 0x1001_0003, size=11 -> done+fault 1 cycle after accept, no RAM strobes, rdata unchanged.
// - MEM_RANGE_CHECK_EN: lw 0x1001_1000 (DEPTH=1024) -> fault=1; lw 0x1001_0FFC -> normal; undefined -> both access RAM.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU load/store initiator for a word-only sync RAM, sub-word stores by read-modify-write
// Optional address range fault: define MEM_RANGE_CHECK_EN.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        ram_rena,
    output logic        ram_wena,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misalign;
    logic        out_of_range;
    logic        req_fault;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;
    logic [31:0] load_val;

    always_comb begin
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr[0];
            2'b10:   misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

`ifdef MEM_RANGE_CHECK_EN
    // End bound in 33 bits so a window touching 4 GiB cannot wrap to zero.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);
    assign out_of_range = (addr < BASE_ADDR) || ({1'b0, addr} >= END_ADDR);
`else
    assign out_of_range = 1'b0;
`endif

    assign req_fault = misalign | out_of_range;

    // Lane extraction for loads and lane insertion for sub-word stores, both from the captured RAM word.
    always_comb begin
        merged   = ram_dout;
        load_val = ram_dout;
        byte_sel = ram_dout[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (size_q)
            2'b00: begin
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
                load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata[15:0];
                    fault_d = req_fault;
                    word_d  = wdata;
                    if (req_fault)
                        state_d = S_FIN;
                    else if (we && (size == 2'b10))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                if (we_q) begin
                    word_d  = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_FIN;
                end
            end
            S_WR:    state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 16'h0;
            fault_q <= 1'b0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign fault    = (state_q == S_FIN) & fault_q;
    assign ram_rena = (state_q == S_RD);
    assign ram_wena = (state_q == S_WR);
    assign ram_addr = {addr_q[31:2], 2'b00};
    assign ram_din  = word_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl against a request-level model
module tb_mem_access_ctrl;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy, done, fault, ram_rena, ram_wena;
    logic [31:0] ram_addr, ram_din;
    logic [31:0] ram_dout = 32'h0;

    mem_access_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fault(fault),
        .ram_rena(ram_rena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] ram  [DEPTH];
    logic [31:0] gmem [DEPTH];

    always @(posedge clk) begin
        if (ram_wena) ram[ram_addr[11:2]] <= ram_din;
        if (ram_rena) ram_dout <= ram[ram_addr[11:2]];
    end

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: outcome and cycles-to-done computed per accepted request.
    int          m_left = 0;
    bit          m_fault, m_load, m_store;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_pend, m_addr = 32'h0;
    int          m_idx = 0, exp_r = 0, exp_w = 0, cnt_r = 0, cnt_w = 0;

    function automatic bit model_fault(input logic [1:0] s, input logic [31:0] a);
        bit f;
        f = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`ifdef MEM_RANGE_CHECK_EN
        if (a < BASE || 64'(a) >= 64'(BASE) + 64'(4 * DEPTH)) f = 1'b1;
`endif
        return f;
    endfunction

    task automatic model_accept();
        int sh;
        logic [31:0] w, v, mask;
        m_idx   = int'((addr >> 2) % DEPTH);
        m_addr  = addr;
        m_fault = model_fault(size, addr);
        m_load  = 1'b0;
        m_store = 1'b0;
        cnt_r   = 0;
        cnt_w   = 0;
        sh      = 8 * int'(addr[1:0]);
        w       = gmem[m_idx];
        if (m_fault) begin
            m_left = 1; exp_r = 0; exp_w = 0;
        end else if (!we) begin
            m_left = 3; exp_r = 1; exp_w = 0; m_load = 1'b1;
            v = w >> sh;
            if (size == 2'd0) begin
                v = v & 32'hFF;
                if (sign_ext && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                v = v & 32'hFFFF;
                if (sign_ext && v[15]) v = v | 32'hFFFF_0000;
            end
            m_pend = v;
        end else if (size == 2'd2) begin
            m_left = 2; exp_r = 0; exp_w = 1; m_store = 1'b1; m_pend = wdata;
        end else begin
            m_left = 4; exp_r = 1; exp_w = 1; m_store = 1'b1;
            mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            m_pend = (w & ~mask) | ((wdata << sh) & mask);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_rdata = 32'h0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1 && m_load)  m_rdata = m_pend;
            if (m_left == 1 && m_store) gmem[m_idx] = m_pend;
        end else if (req) begin
            model_accept();
        end
    end

    always @(negedge clk) begin
        chk("busy",  {31'h0, busy},  {31'h0, m_left != 0});
        chk("done",  {31'h0, done},  {31'h0, m_left == 1});
        chk("fault", {31'h0, fault}, {31'h0, m_left == 1 && m_fault});
        chk("rdata", rdata, m_rdata);
        if (ram_rena) cnt_r++;
        if (ram_wena) cnt_w++;
        if (rst_n && (ram_rena || ram_wena)) begin
            chk("strobe_when_active", {31'h0, m_left > 1}, 32'h1);
            chk("ram_addr", ram_addr, {m_addr[31:2], 2'b00});
        end
        if (rst_n && m_left == 1) begin
            chk("rd_count", 32'(cnt_r), 32'(exp_r));
            chk("wr_count", 32'(cnt_w), 32'(exp_w));
            chk("ram_word", ram[m_idx], gmem[m_idx]);
        end
    end

    task automatic do_req(input bit w, input logic [1:0] s, input bit se, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; size = s; sign_ext = se; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", {31'h0, done}, 32'h1);
    endtask

    int  lat;
    bit  rc;

    initial begin
`ifdef MEM_RANGE_CHECK_EN
        rc = 1'b1;
`else
        rc = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = 32'h0;
            gmem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_strobes", {30'h0, ram_rena, ram_wena}, 32'h0);
        #2 rst_n = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, BASE, 32'hDEAD_BEEF, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0, lat);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd0, 1'b0, BASE + 2, 32'h0000_0055, lat);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_word", ram[0], 32'hDE55_BEEF);
        chk("sb_rds", 32'(cnt_r), 32'd1);
        chk("sb_wrs", 32'(cnt_w), 32'd1);
        do_req(1'b0, 2'd0, 1'b1, BASE, 32'h0, lat);
        chk("lb_data", rdata, 32'hFFFF_FFEF);
        do_req(1'b0, 2'd1, 1'b0, BASE + 2, 32'h0, lat);
        chk("lhu_data", rdata, 32'h0000_DE55);
        do_req(1'b0, 2'd1, 1'b1, BASE + 2, 32'h0, lat);
        chk("lh_data", rdata, 32'hFFFF_DE55);

        do_req(1'b0, 2'd2, 1'b0, BASE + 1, 32'h0, lat);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_fault", {31'h0, fault}, 32'h1);
        chk("lw_mis_rdata", rdata, 32'hFFFF_DE55);
        chk("lw_mis_strobes", 32'(cnt_r + cnt_w), 32'd0);
        do_req(1'b1, 2'd1, 1'b0, BASE + 3, 32'h1234, lat);
        chk("sh_mis_fault", {31'h0, fault}, 32'h1);
        chk("sh_mis_word", ram[0], 32'hDE55_BEEF);
        do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0, lat);
        chk("size11_fault", {31'h0, fault}, 32'h1);
        chk("size11_lat", 32'(lat), 32'd1);

        do_req(1'b0, 2'd2, 1'b0, BASE + 32'h1000, 32'h0, lat);
        chk("range_hi_fault", {31'h0, fault}, {31'h0, rc});
        chk("range_hi_lat", 32'(lat), rc ? 32'd1 : 32'd3);
        do_req(1'b0, 2'd2, 1'b0, BASE + 32'h0FFC, 32'h0, lat);
        chk("range_last_fault", {31'h0, fault}, 32'h0);
        chk("range_last_lat", 32'(lat), 32'd3);

        // Async reset while the sub-word store sits in RD: no write, no done, state cleared at once.
        do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; addr = BASE + 1; wdata = 32'hAA;
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_rdata", rdata, 32'h0);
        chk("midrd_busy", {31'h0, busy}, 32'h0);
        chk("midrd_done", {31'h0, done}, 32'h0);
        chk("midrd_rena", {31'h0, ram_rena}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrd_word", ram[0], 32'hDE55_BEEF);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            req      = ($urandom_range(0, 2) != 0);
            we       = $urandom_range(0, 1) != 0;
            size     = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sign_ext = $urandom_range(0, 1) != 0;
            wdata    = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = BASE + 32'h1000 + 32'($urandom_range(0, 15));
                1:       addr = BASE - 32'($urandom_range(1, 8));
                2, 3:    addr = BASE + 32'($urandom_range(0, 127));
                default: addr = BASE + 32'($urandom_range(0, 31) * 4)
                              + ((size == 2'd1) ? 32'($urandom_range(0, 1) * 2) : 32'h0);
            endcase
        end
        @(negedge clk);
        req = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
